// File: rtl/vram_arbiter.sv
// vram_arbiter: sequences NREQ requesters onto one external VRAM port.
// Bus cycle: IDLE -> SETUP -> STROBE (WAIT cycles) -> HOLD; a new access may be
// accepted in IDLE or HOLD, so back-to-back accesses keep mcs_n low.
// Locked-out requesters are answered locally one cycle later: reads return
// all ones, writes are dropped, and the VRAM strobes are never touched.
// Optional feature macro: VRAM_RR_EN selects round-robin arbitration;
// without it, arbitration is fixed priority with index 0 highest.
module vram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int NREQ   = 3,
    parameter int WAIT   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    input  logic [NREQ-1:0]        lockout,
    output logic [NREQ-1:0]        req_ready,
    output logic [NREQ-1:0]        rsp_valid,
    output logic [NREQ*DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0]      ma,
    output logic [DATA_W-1:0]      md_out,
    output logic                   md_oe,
    input  logic [DATA_W-1:0]      md_in,
    output logic                   mcs_n,
    output logic                   moe_n,
    output logic                   mwr_n,
    output logic                   busy
);

    localparam int         IDX_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [2:0] LAST_CNT = 3'(WAIT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t           state;
    logic [2:0]       wait_cnt;
    logic [IDX_W-1:0] owner;
    logic             cur_we;

    logic [NREQ-1:0]  eligible;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  lock_hit;
    logic             win;
    logic [IDX_W-1:0] win_idx;
    logic             accept_ok;
    logic             bus_done;

    assign accept_ok = !reset && (state == IDLE || state == HOLD);
    assign bus_done  = (state == STROBE) && (wait_cnt == LAST_CNT);
    assign lock_hit  = reset ? '0 : (req_valid & lockout);
    assign eligible  = req_valid & ~lockout;
    assign req_ready = grant | lock_hit;
    assign busy      = (state != IDLE);

`ifdef VRAM_RR_EN
    logic [IDX_W-1:0] rr_last;
    int               rr_idx;

    // Round-robin search starting just after the last bus owner
    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        rr_idx  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = (int'(rr_last) + k) % NREQ;
            if (!win && eligible[rr_idx]) begin
                win     = 1'b1;
                win_idx = IDX_W'(rr_idx);
            end
        end
    end

    // Pointer remembers the last accepted owner; reset value makes index 0 win first
    always_ff @(posedge clk) begin
        if (reset)
            rr_last <= IDX_W'(NREQ - 1);
        else if (accept_ok && win)
            rr_last <= win_idx;
    end
`else
    // Fixed priority: the lowest eligible index wins
    always_comb begin
        win     = 1'b0;
        win_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win     = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    // One-hot bus grant, only when the FSM can take a new access
    always_comb begin
        grant = '0;
        if (accept_ok && win)
            grant[win_idx] = 1'b1;
    end

    // Bus FSM with registered strobes; outputs are loaded for the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            owner    <= '0;
            cur_we   <= 1'b0;
            ma       <= '0;
            md_out   <= '0;
            md_oe    <= 1'b0;
            mcs_n    <= 1'b1;
            moe_n    <= 1'b1;
            mwr_n    <= 1'b1;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (win) begin
                        state  <= SETUP;
                        owner  <= win_idx;
                        cur_we <= req_we[win_idx];
                        ma     <= req_addr[win_idx*ADDR_W +: ADDR_W];
                        if (req_we[win_idx])
                            md_out <= req_wdata[win_idx*DATA_W +: DATA_W];
                        mcs_n  <= 1'b0;
                        moe_n  <= req_we[win_idx];
                        mwr_n  <= 1'b1;
                        md_oe  <= req_we[win_idx];
                    end else begin
                        state <= IDLE;
                        mcs_n <= 1'b1;
                        moe_n <= 1'b1;
                        mwr_n <= 1'b1;
                        md_oe <= 1'b0;
                    end
                end
                SETUP: begin
                    state    <= STROBE;
                    wait_cnt <= '0;
                    mwr_n    <= !cur_we;
                end
                STROBE: begin
                    if (wait_cnt == LAST_CNT) begin
                        // Write data stays driven through HOLD for hold time
                        state <= HOLD;
                        moe_n <= 1'b1;
                        mwr_n <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion pulses and per-requester read data (bus and lockout paths)
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= lock_hit;
            for (int i = 0; i < NREQ; i++) begin
                if (lock_hit[i] && !req_we[i])
                    rsp_data[i*DATA_W +: DATA_W] <= '1;
            end
            // md_in is captured at the edge leaving the last STROBE cycle
            if (bus_done) begin
                rsp_valid[owner] <= 1'b1;
                if (!cur_we)
                    rsp_data[owner*DATA_W +: DATA_W] <= md_in;
            end
        end
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Parametrised VRAM access sequencer for the video memory bus. It arbitrates NREQ requesters (PPU fetch, OAM DMA, CPU, etc.) onto a single external VRAM port and generates the chip-select, output-enable and write strobes with a programmable wait count. It captures read data per requester, and answers locked-out requesters (CPU during pixel transfer) with all-ones reads and dropped writes.

## Interface
Parameters:
- ADDR_W, 13, VRAM address width.
- DATA_W, 8, data width.
- NREQ, 3, requester count; index 0 has highest fixed priority.
- WAIT, 1, STROBE length in cycles; legal range 1–4.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NREQ  access request per requester.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  packed addresses; slice i belongs to requester i.
- req_wdata  in  NREQ*DATA_W  packed write data.
- lockout  in  NREQ  requester i is barred from the bus.
- req_ready  out  NREQ  combinational accept; a handshake completes when valid & ready are both high at a clock edge.
- rsp_valid  out  NREQ  one-cycle read/write completion pulse.
- rsp_data  out  NREQ*DATA_W  per-requester read data, held until that requester's next completion.
- ma  out  ADDR_W  VRAM address.
- md_out  out  DATA_W  write data to pins.
- md_oe  out  1  pin driver enable.
- md_in  in  DATA_W  pin read data.
- mcs_n, moe_n, mwr_n  out  1 each  active-low strobes.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, SETUP, STROBE (WAIT cycles, tracked by a counter), HOLD.
- Bus acceptance happens only in IDLE or HOLD. The winner is the lowest-index i with req_valid[i] & !lockout[i]; req_ready[i] is high for the winner only. On acceptance, addr, we and wdata are registered, the owner index is stored, and the FSM goes to SETUP. With no winner, the FSM goes (or stays) IDLE.
- SETUP: ma = captured address; mcs_n=0; reads moe_n=0; writes md_oe=1, md_out=wdata.
- STROBE: reads keep moe_n=0; writes assert mwr_n=0 and md_oe=1. md_in is sampled at the edge leaving the last STROBE cycle.
- HOLD: mcs_n=0, moe_n=1, mwr_n=1; writes keep md_oe=1 for data hold. rsp_valid[owner]=1. For reads, rsp_data[owner] = the sampled value.
- Back-to-back: an acceptance in HOLD goes directly to SETUP, and mcs_n stays low continuously.
- Lockout path: requester i with req_valid[i] & lockout[i] gets req_ready[i]=1 in any state, independent of the bus. The next cycle it gets rsp_valid[i]=1; a read returns rsp_data[i] = all ones; a write is discarded. This path never touches the strobes and can coincide with a bus completion for another requester.
- A lockout change while an access is in flight does not abort that access.
- Reset values: state IDLE; ma=0; md_out=0; md_oe=0; mcs_n=moe_n=mwr_n=1; req_ready=0; rsp_valid=0; rsp_data=0; busy=0.
- Reset asserted mid-access: on the next edge all strobes go inactive and md_oe=0. No rsp_valid is issued for the aborted access. Requester i's rsp_data returns to 0.

## Timing
- A bus access accepted at edge T has SETUP at T+1, STROBE at T+2…T+1+WAIT, and HOLD (rsp_valid) at T+2+WAIT.
- Read latency is 2+WAIT cycles from acceptance to rsp_valid. Sustained throughput is one access per 2+WAIT cycles.
- Lockout latency is 1 cycle; sustained throughput is one per cycle per requester.
- req_ready is a combinational function of state, req_valid and lockout; no combinational path runs from md_in to any output.
- Requesters hold valid, addr, we and wdata stable until the handshake completes. Dropping valid before ready is allowed and cancels the request.

## Configuration
- VRAM_RR_EN defined: arbitration is round-robin. The search starts at (last owner + 1) mod NREQ. The pointer updates only on bus acceptances and resets to NREQ-1, so requester 0 wins first.
- VRAM_RR_EN undefined: fixed priority, index 0 highest. No pointer register exists.

## Test plan
- Single read, WAIT=1, req 2, addr 0x1ABC, md_in=0x5A: req_ready at T; moe_n/mcs_n low T+1..T+2; rsp_valid[2] at T+3; rsp_data[2]=0x5A.
- Write from req 1, addr 0x0010, data 0xC3, WAIT=2: mwr_n low exactly at T+2..T+3; md_oe high T+1..T+4; md_out=0xC3 throughout.
- Req 0 and 2 valid together, fixed priority: req 0 served first, req 2 accepted in req 0's HOLD cycle, mcs_n never returns high between the two accesses. With VRAM_RR_EN and req 0 just served, req 2 wins.
- lockout[2]=1, read from req 2 while req 0 is mid-access: req_ready[2] immediately; rsp_valid[2] next cycle with data 0xFF; req 0 timing unchanged; a locked write leaves VRAM unwritten (mwr_n never low for it).
- Reset asserted during STROBE of a write: the next cycle has mwr_n=mcs_n=1, md_oe=0, no rsp_valid, busy=0; a fresh read afterwards completes normally.
- Sweep WAIT=1..4 with back-to-back reads: rsp_valid spacing equals 2+WAIT cycles.
